// File: rtl/dvp_frame_ctrl.sv
// dvp_frame_ctrl: arms on command, aligns to vsync, forwards checked frames to an AXIS sink
`timescale 1ns/1ps
module dvp_frame_ctrl #(
    parameter int WIDTH_P = 8,
    parameter int COLS_P  = 640,
    parameter int ROWS_P  = 480
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               cont_i,
    input  logic               abort_i,
    input  logic               vsync_i,
    input  logic [WIDTH_P-1:0] s_tdata_i,
    input  logic               s_tvalid_i,
    input  logic               s_tlast_i,
    output logic               s_tready_o,
    output logic [WIDTH_P-1:0] m_tdata_o,
    output logic               m_tvalid_o,
    output logic               m_tlast_o,
    output logic               m_tuser_o,
    input  logic               m_tready_i,
    output logic               busy_o,
    output logic               frame_done_o,
    output logic               err_o,
    output logic [1:0]         err_code_o,
    output logic [15:0]        frame_cnt_o
);
    localparam int CW = $clog2(COLS_P + 1);
    localparam int RW = $clog2(ROWS_P + 1);
    localparam logic [CW-1:0] COLS_L = CW'(COLS_P);
    localparam logic [RW-1:0] ROWS_L = RW'(ROWS_P);
    typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE, DROP} state_t;
    state_t             r_state, w_state_n;
    logic               r_vs_d;
    logic [CW-1:0]      r_col, w_col_n, w_col_inc;
    logic [RW-1:0]      r_row, w_row_n, w_row_inc;
    logic               r_sof_pend, w_sof_n;
    logic [WIDTH_P-1:0] r_m_tdata;
    logic               r_m_tvalid, r_m_tlast, r_m_tuser;
    logic               r_done, r_err, w_done, w_err;
    logic [1:0]         r_err_code, w_code_n;
    logic [15:0]        r_frame_cnt;
    logic               w_vs_rise, w_free, w_beat, w_accept, w_ovf, w_end_col;
    logic               w_line_err, w_good_last, w_frame_end, w_fwd;
    assign w_vs_rise   = vsync_i & ~r_vs_d;
    assign w_free      = ~r_m_tvalid | m_tready_i;
    assign w_beat      = (r_state == ACTIVE) & s_tvalid_i;
    assign w_accept    = w_beat & w_free;
    assign w_ovf       = w_beat & ~w_free;
    assign w_col_inc   = r_col + CW'(1);
    assign w_row_inc   = r_row + RW'(1);
    assign w_end_col   = w_col_inc == COLS_L;
    assign w_line_err  = w_accept & (s_tlast_i ^ w_end_col);
    assign w_good_last = w_accept & s_tlast_i & w_end_col;
    assign w_frame_end = w_good_last & (w_row_inc == ROWS_L);
    assign w_fwd       = w_accept & ~w_line_err & ~abort_i;
    assign s_tready_o   = 1'b1;
    assign m_tdata_o    = r_m_tdata;
    assign m_tvalid_o   = r_m_tvalid;
    assign m_tlast_o    = r_m_tlast;
    assign m_tuser_o    = r_m_tuser;
    assign busy_o       = r_state != IDLE;
    assign frame_done_o = r_done;
    assign err_o        = r_err;
    assign err_code_o   = r_err_code;
    assign frame_cnt_o  = r_frame_cnt;
    // Next state, frame counters and status; the beat is judged before a coincident vsync edge
    always_comb begin
        w_state_n = r_state;
        w_col_n   = r_col;
        w_row_n   = r_row;
        w_sof_n   = r_sof_pend;
        w_done    = 1'b0;
        w_err     = 1'b0;
        w_code_n  = r_err_code;
        if (abort_i) begin
            w_state_n = IDLE;
        end else begin
            case (r_state)
                IDLE: w_state_n = start_i ? WAIT_VS : IDLE;
                WAIT_VS: begin
                    if (w_vs_rise) begin
                        w_state_n = ACTIVE;
                        w_col_n   = '0;
                        w_row_n   = '0;
                        w_sof_n   = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (w_line_err || w_ovf) begin
                        w_err     = 1'b1;
                        w_code_n  = w_line_err ? 2'd1 : 2'd3;
                        w_state_n = DROP;
                    end else begin
                        if (w_accept) begin
                            w_col_n = w_good_last ? '0 : w_col_inc;
                            w_row_n = w_good_last ? w_row_inc : r_row;
                            w_sof_n = 1'b0;
                        end
                        if (w_frame_end) begin
                            w_done    = 1'b1;
                            w_state_n = cont_i ? WAIT_VS : IDLE;
                        end else if (w_vs_rise) begin
                            w_err     = 1'b1;
                            w_code_n  = 2'd2;
                            w_state_n = IDLE;
                        end
                        if (w_vs_rise && cont_i) begin
                            w_state_n = ACTIVE;
                            w_col_n   = '0;
                            w_row_n   = '0;
                            w_sof_n   = 1'b1;
                        end
                    end
                end
                default: begin
                    if (w_vs_rise) begin
                        w_state_n = cont_i ? ACTIVE : IDLE;
                        w_col_n   = '0;
                        w_row_n   = '0;
                        w_sof_n   = 1'b1;
                    end
                end
            endcase
        end
    end
    // State, counters and status registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_vs_d      <= 1'b0;
            r_col       <= '0;
            r_row       <= '0;
            r_sof_pend  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= 2'd0;
            r_frame_cnt <= 16'd0;
        end else begin
            r_state     <= w_state_n;
            r_vs_d      <= vsync_i;
            r_col       <= w_col_n;
            r_row       <= w_row_n;
            r_sof_pend  <= w_sof_n;
            r_done      <= w_done;
            r_err       <= w_err;
            r_err_code  <= w_code_n;
            r_frame_cnt <= r_frame_cnt + {15'd0, w_done};
        end
    end
    // Output slot: loads only when empty or draining, so a stalled beat holds stable
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tuser  <= 1'b0;
        end else if (w_free) begin
            r_m_tvalid <= w_fwd;
            r_m_tdata  <= s_tdata_i;
            r_m_tlast  <= s_tlast_i;
            r_m_tuser  <= r_sof_pend;
        end
    end
endmodule

// File: tb/tb_dvp_frame_ctrl.sv
// tb_dvp_frame_ctrl: directed vector table plus reset sequences for dvp_frame_ctrl
`timescale 1ns/1ps
module tb_dvp_frame_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic st, ct, ab, vs, v, l, rdy;
    logic [7:0] d;
    logic s_tready, m_tvalid, m_tlast, m_tuser, busy, done, err;
    logic [7:0] m_tdata;
    logic [1:0] err_code;
    logic [15:0] frame_cnt;
    int n_vec = 0, n_err = 0;
    typedef struct {
        logic st, ct, ab, vs;
        logic [7:0] d;
        logic v, l, rdy, mv;
        logic [7:0] md;
        logic ml, mu, bz, dn, er;
        logic [1:0] ec;
        logic [15:0] fc;
    } vec_t;
    vec_t tbl[$];
    always #5 clk = ~clk;
    dvp_frame_ctrl #(.WIDTH_P(8), .COLS_P(4), .ROWS_P(2)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(st), .cont_i(ct), .abort_i(ab), .vsync_i(vs),
        .s_tdata_i(d), .s_tvalid_i(v), .s_tlast_i(l), .s_tready_o(s_tready),
        .m_tdata_o(m_tdata), .m_tvalid_o(m_tvalid), .m_tlast_o(m_tlast), .m_tuser_o(m_tuser),
        .m_tready_i(rdy), .busy_o(busy), .frame_done_o(done), .err_o(err),
        .err_code_o(err_code), .frame_cnt_o(frame_cnt)
    );
    function automatic void add(input logic ist, ict, iab, ivs, input logic [7:0] id,
                                input logic iv, il, irdy, imv, input logic [7:0] imd,
                                input logic iml, imu, ibz, idn, ier, input logic [1:0] iec,
                                input logic [15:0] ifc);
        vec_t t;
        t.st = ist; t.ct = ict; t.ab = iab; t.vs = ivs; t.d = id; t.v = iv; t.l = il; t.rdy = irdy;
        t.mv = imv; t.md = imd; t.ml = iml; t.mu = imu; t.bz = ibz; t.dn = idn; t.er = ier;
        t.ec = iec; t.fc = ifc;
        tbl.push_back(t);
    endfunction
    task automatic chk_status(input string nm, input logic emv, ebz, input logic [1:0] eec,
                              input logic [15:0] efc);
        n_vec++;
        if (m_tvalid !== emv || busy !== ebz || err_code !== eec || frame_cnt !== efc ||
            done !== 1'b0 || err !== 1'b0 || s_tready !== 1'b1) begin
            n_err++;
            $display("FAIL %s: got mv=%b busy=%b done=%b err=%b code=%0d cnt=%0d rdy=%b, exp mv=%b busy=%b done=0 err=0 code=%0d cnt=%0d rdy=1",
                     nm, m_tvalid, busy, done, err, err_code, frame_cnt, s_tready, emv, ebz, eec, efc);
        end
    endtask
    task automatic step(input logic ist, ivs, input logic [7:0] id, input logic iv, irdy);
        @(negedge clk);
        st = ist; ct = 1'b0; ab = 1'b0; vs = ivs; d = id; v = iv; l = 1'b0; rdy = irdy;
        @(posedge clk);
        #1;
    endtask
    initial begin
        st = 0; ct = 0; ab = 0; vs = 0; d = 0; v = 0; l = 0; rdy = 1;
        //   st ct ab vs  d      v  l  rdy  mv md     ml mu  bz dn er ec fc
        // single frame, cont=0, with a stray pixel before vsync
        add(1, 0, 0, 0, 8'h00, 0, 0, 1,   0, 8'h00, 0, 0,  1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 8'hAA, 1, 0, 1,   0, 8'h00, 0, 0,  1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 8'h00, 0, 0, 1,   0, 8'h00, 0, 0,  1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 8'h10, 1, 0, 1,   1, 8'h10, 0, 1,  1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 8'h11, 1, 0, 1,   1, 8'h11, 0, 0,  1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 8'h12, 1, 0, 1,   1, 8'h12, 0, 0,  1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 8'h13, 1, 1, 1,   1, 8'h13, 1, 0,  1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 8'h14, 1, 0, 1,   1, 8'h14, 0, 0,  1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 8'h15, 1, 0, 1,   1, 8'h15, 0, 0,  1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 8'h16, 1, 0, 1,   1, 8'h16, 0, 0,  1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 8'h17, 1, 1, 1,   1, 8'h17, 1, 0,  0, 1, 0, 0, 1);
        add(0, 0, 0, 0, 8'h00, 0, 0, 1,   0, 8'h00, 0, 0,  0, 0, 0, 0, 1);
        // short line (tlast on 3rd pixel), cont=1, then a clean frame
        add(1, 1, 0, 0, 8'h00, 0, 0, 1,   0, 8'h00, 0, 0,  1, 0, 0, 0, 1);
        add(0, 1, 0, 1, 8'h00, 0, 0, 1,   0, 8'h00, 0, 0,  1, 0, 0, 0, 1);
        add(0, 1, 0, 0, 8'h20, 1, 0, 1,   1, 8'h20, 0, 1,  1, 0, 0, 0, 1);
        add(0, 1, 0, 0, 8'h21, 1, 0, 1,   1, 8'h21, 0, 0,  1, 0, 0, 0, 1);
        add(0, 1, 0, 0, 8'h22, 1, 1, 1,   0, 8'h00, 0, 0,  1, 0, 1, 1, 1);
        add(0, 1, 0, 0, 8'h23, 1, 0, 1,   0, 8'h00, 0, 0,  1, 0, 0, 1, 1);
        add(0, 1, 0, 1, 8'h00, 0, 0, 1,   0, 8'h00, 0, 0,  1, 0, 0, 1, 1);
        add(0, 1, 0, 0, 8'h30, 1, 0, 1,   1, 8'h30, 0, 1,  1, 0, 0, 1, 1);
        add(0, 1, 0, 0, 8'h31, 1, 0, 1,   1, 8'h31, 0, 0,  1, 0, 0, 1, 1);
        add(0, 1, 0, 0, 8'h32, 1, 0, 1,   1, 8'h32, 0, 0,  1, 0, 0, 1, 1);
        add(0, 1, 0, 0, 8'h33, 1, 1, 1,   1, 8'h33, 1, 0,  1, 0, 0, 1, 1);
        add(0, 1, 0, 0, 8'h34, 1, 0, 1,   1, 8'h34, 0, 0,  1, 0, 0, 1, 1);
        add(0, 1, 0, 0, 8'h35, 1, 0, 1,   1, 8'h35, 0, 0,  1, 0, 0, 1, 1);
        add(0, 1, 0, 0, 8'h36, 1, 0, 1,   1, 8'h36, 0, 0,  1, 0, 0, 1, 1);
        add(0, 1, 0, 0, 8'h37, 1, 1, 1,   1, 8'h37, 1, 0,  1, 1, 0, 1, 2);
        // short frame: vsync after one line, next frame restarts with tuser
        add(0, 1, 0, 1, 8'h00, 0, 0, 1,   0, 8'h00, 0, 0,  1, 0, 0, 1, 2);
        add(0, 1, 0, 0, 8'h40, 1, 0, 1,   1, 8'h40, 0, 1,  1, 0, 0, 1, 2);
        add(0, 1, 0, 0, 8'h41, 1, 0, 1,   1, 8'h41, 0, 0,  1, 0, 0, 1, 2);
        add(0, 1, 0, 0, 8'h42, 1, 0, 1,   1, 8'h42, 0, 0,  1, 0, 0, 1, 2);
        add(0, 1, 0, 0, 8'h43, 1, 1, 1,   1, 8'h43, 1, 0,  1, 0, 0, 1, 2);
        add(0, 1, 0, 1, 8'h00, 0, 0, 1,   0, 8'h00, 0, 0,  1, 0, 1, 2, 2);
        add(0, 1, 0, 0, 8'h50, 1, 0, 1,   1, 8'h50, 0, 1,  1, 0, 0, 2, 2);
        add(0, 1, 0, 0, 8'h51, 1, 0, 1,   1, 8'h51, 0, 0,  1, 0, 0, 2, 2);
        add(0, 1, 0, 0, 8'h52, 1, 0, 1,   1, 8'h52, 0, 0,  1, 0, 0, 2, 2);
        add(0, 1, 0, 0, 8'h53, 1, 1, 1,   1, 8'h53, 1, 0,  1, 0, 0, 2, 2);
        add(0, 1, 0, 0, 8'h54, 1, 0, 1,   1, 8'h54, 0, 0,  1, 0, 0, 2, 2);
        add(0, 1, 0, 0, 8'h55, 1, 0, 1,   1, 8'h55, 0, 0,  1, 0, 0, 2, 2);
        add(0, 1, 0, 0, 8'h56, 1, 0, 1,   1, 8'h56, 0, 0,  1, 0, 0, 2, 2);
        // last beat and vsync together: done, straight into the next frame
        add(0, 1, 0, 1, 8'h57, 1, 1, 1,   1, 8'h57, 1, 0,  1, 1, 0, 2, 3);
        add(0, 1, 0, 0, 8'h60, 1, 0, 1,   1, 8'h60, 0, 1,  1, 0, 0, 2, 3);
        // overflow: sink stalls, second pixel discarded, first held
        add(0, 1, 0, 0, 8'h61, 1, 0, 0,   1, 8'h60, 0, 1,  1, 0, 1, 3, 3);
        add(0, 1, 0, 0, 8'h00, 0, 0, 0,   1, 8'h60, 0, 1,  1, 0, 0, 3, 3);
        add(0, 1, 0, 0, 8'h62, 1, 0, 1,   0, 8'h00, 0, 0,  1, 0, 0, 3, 3);
        add(0, 0, 0, 1, 8'h00, 0, 0, 1,   0, 8'h00, 0, 0,  0, 0, 0, 3, 3);
        add(0, 0, 0, 0, 8'h00, 0, 0, 1,   0, 8'h00, 0, 0,  0, 0, 0, 3, 3);
        // abort mid-line with start in the same cycle; held beat survives
        add(1, 0, 0, 0, 8'h00, 0, 0, 1,   0, 8'h00, 0, 0,  1, 0, 0, 3, 3);
        add(0, 0, 0, 1, 8'h00, 0, 0, 1,   0, 8'h00, 0, 0,  1, 0, 0, 3, 3);
        add(0, 0, 0, 0, 8'h70, 1, 0, 1,   1, 8'h70, 0, 1,  1, 0, 0, 3, 3);
        add(0, 0, 0, 0, 8'h71, 1, 0, 1,   1, 8'h71, 0, 0,  1, 0, 0, 3, 3);
        add(1, 0, 1, 0, 8'h72, 1, 0, 0,   1, 8'h71, 0, 0,  0, 0, 0, 3, 3);
        add(0, 0, 0, 0, 8'h73, 1, 0, 0,   1, 8'h71, 0, 0,  0, 0, 0, 3, 3);
        add(0, 0, 0, 0, 8'h74, 1, 0, 1,   0, 8'h00, 0, 0,  0, 0, 0, 3, 3);
        repeat (2) @(posedge clk);
        #1;
        chk_status("reset", 1'b0, 1'b0, 2'd0, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            st = tbl[i].st; ct = tbl[i].ct; ab = tbl[i].ab; vs = tbl[i].vs;
            d = tbl[i].d; v = tbl[i].v; l = tbl[i].l; rdy = tbl[i].rdy;
            @(posedge clk);
            #1;
            n_vec++;
            if (m_tvalid !== tbl[i].mv || busy !== tbl[i].bz || done !== tbl[i].dn ||
                err !== tbl[i].er || err_code !== tbl[i].ec || frame_cnt !== tbl[i].fc ||
                s_tready !== 1'b1 ||
                (tbl[i].mv && (m_tdata !== tbl[i].md || m_tlast !== tbl[i].ml || m_tuser !== tbl[i].mu))) begin
                n_err++;
                $display("FAIL vec%0d: got mv=%b d=%h last=%b user=%b busy=%b done=%b err=%b code=%0d cnt=%0d, exp mv=%b d=%h last=%b user=%b busy=%b done=%b err=%b code=%0d cnt=%0d",
                         i, m_tvalid, m_tdata, m_tlast, m_tuser, busy, done, err, err_code, frame_cnt,
                         tbl[i].mv, tbl[i].md, tbl[i].ml, tbl[i].mu, tbl[i].bz, tbl[i].dn, tbl[i].er,
                         tbl[i].ec, tbl[i].fc);
            end
        end
        // reset while a stalled beat is held mid-frame
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h80, 1'b1, 1'b0);
        chk_status("held_before_rst", 1'b1, 1'b1, 2'd3, 16'd3);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_status("rst_mid_frame", 1'b0, 1'b0, 2'd0, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b1, 8'h81, 1'b1, 1'b1);
        step(1'b0, 1'b1, 8'h82, 1'b1, 1'b1);
        chk_status("idle_after_rst", 1'b0, 1'b0, 2'd0, 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dvp_frame_ctrl.md
Name: dvp_frame_ctrl

Overview:
Frame-capture controller placed directly after the DVP-to-AXI-Stream converter. It arms capture on command and aligns to the next vsync rising edge. It forwards whole frames to the downstream AXIS sink with tuser marking start-of-frame, checks line length and line count, and drops malformed or overflowed frames. Software-facing status is provided as busy, done and error pulses plus a completed-frame counter.

Parameters:
WIDTH_P, 8, pixel data width in bits
COLS_P, 640, required pixels per line (must be >= 2)
ROWS_P, 480, required lines per frame (must be >= 1)

Ports:
clk_i  in  1  pixel-domain clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  arm pulse; ignored unless state is IDLE
cont_i  in  1  level; 1 = continuous capture, 0 = single frame
abort_i  in  1  pulse; return to IDLE
vsync_i  in  1  raw DVP frame sync
s_tdata_i  in  WIDTH_P  upstream pixel
s_tvalid_i  in  1  upstream valid
s_tlast_i  in  1  upstream end-of-line
s_tready_o  out  1  constant 1; the source cannot stall
m_tdata_o  out  WIDTH_P  downstream pixel
m_tvalid_o  out  1  downstream valid
m_tlast_o  out  1  end-of-line
m_tuser_o  out  1  first pixel of frame
m_tready_i  in  1  downstream ready
busy_o  out  1  state != IDLE
frame_done_o  out  1  one-cycle pulse per good frame
err_o  out  1  one-cycle pulse on any error
err_code_o  out  2  last error: 1 LINE, 2 SHORT_FRAME, 3 OVERFLOW; held until next error
frame_cnt_o  out  16  good frames since reset; wraps at 0xFFFF -> 0

Behaviour:
- Reset: state IDLE. All outputs are 0 except s_tready_o = 1. col, row, sof_pend, vs_d and frame_cnt are all cleared to 0.
- vs_rise = vsync_i & ~vs_d, where vs_d is vsync_i registered.
- States: IDLE, WAIT_VS, ACTIVE, DROP.
- Counters: col has width $clog2(COLS_P+1); row has width $clog2(ROWS_P+1).
- Output slot free = !m_tvalid_o | m_tready_i. When m_tvalid_o && !m_tready_i, m_* outputs hold stable (AXIS rule).
- Accepted beat (ACTIVE, s_tvalid_i, slot free):
  - m_tdata, m_tlast and m_tuser load on the next edge; m_tvalid_o = 1. Latency is 1 cycle.
  - m_tuser = sof_pend; sof_pend then clears.
- Transitions:
  - IDLE: start_i -> WAIT_VS.
  - WAIT_VS: beats are discarded. vs_rise -> ACTIVE with col = 0, row = 0, sof_pend = 1.
  - ACTIVE, each accepted beat: col++.
    - Beat with s_tlast_i and col+1 != COLS_P -> LINE error.
    - Beat with !s_tlast_i and col+1 == COLS_P -> LINE error (long line).
    - Good tlast: col = 0, row++. If row+1 == ROWS_P, pulse frame_done_o and increment frame_cnt; next state is WAIT_VS if cont_i else IDLE.
  - ACTIVE, s_tvalid_i while slot not free: the beat is discarded -> OVERFLOW error.
  - ACTIVE, vs_rise before the frame completes -> SHORT_FRAME error. The rising edge starts a new frame: ACTIVE with counters reset and sof_pend = 1 if cont_i, else IDLE.
  - Any error: err_o pulses and err_code_o updates. LINE and OVERFLOW errors go to DROP. An erroring beat is not forwarded.
  - DROP: discard beats until vs_rise; then ACTIVE (counters reset, sof_pend = 1) if cont_i, else IDLE.
- Simultaneous events:
  - Beat and vs_rise in ACTIVE in the same cycle: the beat is evaluated first against the old frame.
  - If that beat completes the frame and cont_i = 1, go directly to ACTIVE for the new frame instead of WAIT_VS, with no SHORT_FRAME error.
  - If that beat leaves the frame incomplete, SHORT_FRAME is reported.
  - LINE and SHORT_FRAME in the same cycle: report LINE.
- abort_i has priority over everything except reset: next state IDLE, and no done or error pulse that cycle. A held m_* beat stays valid until accepted. start_i in the same cycle as abort_i is ignored.
- Reset mid-frame drops any held beat immediately (m_tvalid_o = 0).

Test Plan:
- COLS_P=4, ROWS_P=2, cont_i=0, m_tready_i=1. Pulse start_i, vsync rise, then 2 lines of 4 pixels (0x10..0x17) -> m beats 0x10..0x17 one cycle late; tuser only on 0x10; tlast on 0x13 and 0x17; frame_done_o pulses once; frame_cnt_o=1; state IDLE, busy_o=0.
- Pixels arriving before the vsync rise while in WAIT_VS -> no m_tvalid_o; first forwarded pixel carries tuser=1.
- Line with tlast on the 3rd pixel -> err_o pulse, err_code_o=1; remaining pixels dropped until vsync. With cont_i=1 the next frame captures cleanly and frame_cnt_o increments.
- Hold m_tready_i=0 while two consecutive pixels arrive -> first pixel held stable; second discarded; err_code_o=3; DROP until vsync.
- cont_i=1: vsync rise after only 1 line -> err_code_o=2; the following frame gets tuser on its first pixel and completes with frame_done_o.
- abort_i mid-line -> IDLE next cycle; later pixels not forwarded; busy_o=0; start_i in the same cycle ignored.
